// File: rtl/pipe_inst_issuer_if.sv
// Host, read-back and pipeline-side signals of the instruction issuer.
// master = host/pipeline environment, slave = issuer.
interface pipe_inst_issuer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [7:0]      in_inst;
    logic            in_ready;
    logic [7:0]      inst;
    logic            rd_req_valid;
    logic [1:0]      rd_req_reg;
    logic            rd_req_ready;
    logic            rd_rsp_valid;
    logic [7:0]      rd_rsp_data;
    logic [1:0]      dummy_read_rf;
    logic [7:0]      dummy_rf_data;
    logic [CntW-1:0] fifo_count;

    modport master (
        output in_valid, in_inst, rd_req_valid, rd_req_reg, dummy_rf_data,
        input  in_ready, inst, rd_req_ready, rd_rsp_valid, rd_rsp_data, dummy_read_rf,
               fifo_count
    );

    modport slave (
        input  in_valid, in_inst, rd_req_valid, rd_req_reg, dummy_rf_data,
        output in_ready, inst, rd_req_ready, rd_rsp_valid, rd_rsp_data, dummy_read_rf,
               fifo_count
    );
endinterface

// File: rtl/pipe_inst_issuer.sv
// Instruction FIFO feeding the add/sub/and pipeline one instruction per cycle, plus a
// register read-back path fenced behind all previously issued writes.
module pipe_inst_issuer #(
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    pipe_inst_issuer_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRead,
        StResp
    } state_e;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      inst_q, inst_d;
    logic [2:0]      drain_cnt_q, drain_cnt_d;
    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            push, pop;

    assign bus.in_ready      = (count_q < CntW'(DEPTH)) && (state_q == StIdle);
    assign bus.inst          = inst_q;
    assign bus.rd_req_ready  = (state_q == StIdle);
    assign bus.rd_rsp_valid  = (state_q == StResp);
    assign bus.rd_rsp_data   = rsp_data_q;
    assign bus.dummy_read_rf = sel_q;
    assign bus.fifo_count    = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        inst_d = pop ? mem_q[rd_ptr_q] : 8'h00;

        // Four edges cover ID->EX, EX result, EX->WB and the RF write.
        if (inst_d[7:6] != 2'b00) begin
            drain_cnt_d = 3'd4;
        end else if (drain_cnt_q != 3'd0) begin
            drain_cnt_d = drain_cnt_q - 3'd1;
        end else begin
            drain_cnt_d = 3'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (bus.rd_req_valid) begin
                    sel_d   = bus.rd_req_reg;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Judged on post-edge values so READ starts the cycle the last write lands.
                if (count_d == '0 && inst_d == 8'h00 && drain_cnt_d == 3'd0) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                rsp_data_d = bus.dummy_rf_data;
                state_d    = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_inst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inst_q      <= 8'h00;
            drain_cnt_q <= 3'd0;
            state_q     <= StIdle;
            sel_q       <= 2'd0;
            rsp_data_q  <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inst_q      <= inst_d;
            drain_cnt_q <= drain_cnt_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_pipe_inst_issuer.sv
// Directed bench for pipe_inst_issuer with a small register-file model on the read-back port.
module tb_pipe_inst_issuer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0] rf [4];

    always #5 clk = ~clk;

    pipe_inst_issuer_if #(.DEPTH(4)) bus ();

    pipe_inst_issuer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb bus.dummy_rf_data = rf[bus.dummy_read_rf];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            total += 4;
            if (bus.inst !== 8'h00) begin
                bad++; $display("FAIL reset_inst: got %h want 00", bus.inst);
            end
            if (bus.in_ready !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
            end
            if (bus.rd_req_ready !== 1'b1) begin
                bad++; $display("FAIL reset_rd_req_ready: got %b want 1", bus.rd_req_ready);
            end
            if (bus.rd_rsp_valid !== 1'b0) begin
                bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rd_rsp_valid);
            end
        end
        total += 3;
        if (bus.fifo_count !== 3'd0) begin
            bad++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count);
        end
        if (bus.rd_rsp_data !== 8'h00) begin
            bad++; $display("FAIL reset_rsp_data: got %h want 00", bus.rd_rsp_data);
        end
        if (bus.dummy_read_rf !== 2'd0) begin
            bad++; $display("FAIL reset_sel: got %0d want 0", bus.dummy_read_rf);
        end
    endtask

    task automatic test_single_issue();
        logic [2:0] exp_drain [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        bus.in_valid = 1'b1;
        bus.in_inst  = 8'h45;
        tick();
        bus.in_valid = 1'b0;
        total += 2;
        if (bus.inst !== 8'h00) begin
            bad++; $display("FAIL issue_no_bypass: got %h want 00", bus.inst);
        end
        if (bus.fifo_count !== 3'd1) begin
            bad++; $display("FAIL issue_count: got %0d want 1", bus.fifo_count);
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            total += 2;
            if (bus.inst !== ((i == 1) ? 8'h45 : 8'h00)) begin
                bad++; $display("FAIL issue_inst[%0d]: got %h want %h", i, bus.inst,
                                (i == 1) ? 8'h45 : 8'h00);
            end
            if (dut.drain_cnt_q !== exp_drain[i-1]) begin
                bad++; $display("FAIL issue_drain[%0d]: got %0d want %0d", i, dut.drain_cnt_q,
                                exp_drain[i-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [5] = '{8'h45, 8'h9A, 8'hB6, 8'h63, 8'h4F};
        logic [7:0] got [$];
        int k = 0;
        int cyc = 0;
        int drops = 0;
        logic rdy;
        bus.in_valid = 1'b1;
        while (k < 5 && cyc < 20) begin
            bus.in_inst = vec[k];
            rdy = bus.in_ready;
            if (!rdy) drops++;
            tick();
            cyc++;
            if (rdy) k++;
            if (bus.inst != 8'h00) got.push_back(bus.inst);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.inst != 8'h00) got.push_back(bus.inst);
        end
        total += 3;
        if (k !== 5) begin
            bad++; $display("FAIL b2b_pushed: got %0d want 5", k);
        end
        if (drops > 1) begin
            bad++; $display("FAIL b2b_ready_drops: got %0d want <=1", drops);
        end
        if (got.size() !== 5) begin
            bad++; $display("FAIL b2b_issued: got %0d want 5", got.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= got.size() || got[i] !== vec[i]) begin
                bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i,
                                (i < got.size()) ? got[i] : 8'hxx, vec[i]);
            end
        end
    endtask

    task automatic test_push_and_read();
        int pulses = 0;
        rf[2] = 8'h5A;
        bus.in_valid     = 1'b1;
        bus.in_inst      = 8'hB6;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_reg   = 2'd2;
        tick();
        bus.in_valid     = 1'b0;
        bus.rd_req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            // Model the RF write four edges after B6 is issued (issued at push+1).
            if (i == 5) rf[2] = 8'hA5;
            if (i == 1) begin
                total++;
                if (bus.inst !== 8'hB6) begin
                    bad++; $display("FAIL pr_issue: got %h want B6", bus.inst);
                end
            end
            total++;
            if (bus.rd_rsp_valid !== (i == 6)) begin
                bad++; $display("FAIL pr_rsp_valid[%0d]: got %b want %b", i, bus.rd_rsp_valid,
                                i == 6);
            end
            if (bus.rd_rsp_valid === 1'b1) begin
                pulses++;
                total++;
                if (bus.rd_rsp_data !== 8'hA5) begin
                    bad++; $display("FAIL pr_rsp_data: got %h want A5", bus.rd_rsp_data);
                end
            end
        end
        total++;
        if (pulses !== 1) begin
            bad++; $display("FAIL pr_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_fence();
        logic [7:0] vec [3] = '{8'h41, 8'h86, 8'h57};
        int seen = -1;
        rf[3] = 8'h3C;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_inst = vec[i];
            if (i == 2) begin
                bus.rd_req_valid = 1'b1;
                bus.rd_req_reg   = 2'd3;
            end
            tick();
        end
        bus.in_valid     = 1'b0;
        bus.rd_req_valid = 1'b0;
        total++;
        if (bus.fifo_count !== 3'd1) begin
            bad++; $display("FAIL fence_count: got %0d want 1", bus.fifo_count);
        end
        for (int i = 1; i <= 30 && seen < 0; i++) begin
            tick();
            total += 2;
            if (bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL fence_in_ready[%0d]: got %b want 0", i, bus.in_ready);
            end
            if (bus.dummy_read_rf !== 2'd3) begin
                bad++; $display("FAIL fence_sel[%0d]: got %0d want 3", i, bus.dummy_read_rf);
            end
            if (bus.rd_rsp_valid === 1'b1) seen = i;
        end
        total += 3;
        if (seen !== 6) begin
            bad++; $display("FAIL fence_rsp_cycle: got %0d want 6", seen);
        end
        if (bus.rd_rsp_data !== 8'h3C) begin
            bad++; $display("FAIL fence_rsp_data: got %h want 3C", bus.rd_rsp_data);
        end
        tick();
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL fence_release: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        rf[1] = 8'h77;
        bus.in_valid     = 1'b1;
        bus.in_inst      = 8'h45;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_reg   = 2'd1;
        tick();
        bus.in_valid     = 1'b0;
        bus.rd_req_valid = 1'b0;
        tick();
        total++;
        if (bus.rd_req_ready !== 1'b0) begin
            bad++; $display("FAIL rw_in_wait: got %b want 0", bus.rd_req_ready);
        end
        #2 rst = 1'b1;
        #1;
        total += 6;
        if (bus.inst !== 8'h00) begin
            bad++; $display("FAIL rw_inst: got %h want 00", bus.inst);
        end
        if (bus.fifo_count !== 3'd0) begin
            bad++; $display("FAIL rw_count: got %0d want 0", bus.fifo_count);
        end
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL rw_in_ready: got %b want 1", bus.in_ready);
        end
        if (bus.rd_req_ready !== 1'b1) begin
            bad++; $display("FAIL rw_rd_req_ready: got %b want 1", bus.rd_req_ready);
        end
        if (bus.dummy_read_rf !== 2'd0) begin
            bad++; $display("FAIL rw_sel: got %0d want 0", bus.dummy_read_rf);
        end
        if (bus.rd_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rw_rsp_valid: got %b want 0", bus.rd_rsp_valid);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (bus.rd_rsp_valid !== 1'b0) begin
                bad++; $display("FAIL rw_no_rsp[%0d]: got %b want 0", i, bus.rd_rsp_valid);
            end
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_inst      = 8'h00;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_reg   = 2'd0;
        for (int i = 0; i < 4; i++) rf[i] = 8'h10 + 8'(i);
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        test_single_issue();
        repeat (3) tick();
        test_back_to_back();
        repeat (6) tick();
        test_push_and_read();
        repeat (3) tick();
        test_fence();
        repeat (3) tick();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
